// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding and a decode helper for ops that take the iterative path.
package alu_pkg;

    // op[3]=0: the original 3-bit datapath codes
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SRA   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_ZERO  = 4'b0111;

    // op[3]=1: iterative multiply/divide (1010 and 1011 yield 0 in one cycle)
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REM   = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for ops that go through the multi-cycle mul/div engine.
    function automatic logic is_iter_op(input logic [3:0] op);
        return op[3] & (op[2] | ~op[1]);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine. One shift-add (mul) or one restoring
// subtract (div) step per cycle while run is high. The last step's result,
// including the sign fixup, is presented combinationally together with done,
// so the owner can capture it on the same edge that performs the final step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;     // mul: product high half, div: partial remainder
    logic [WIDTH-1:0] lo_q;      // mul: multiplier / product low half, div: dividend / quotient
    logic [WIDTH-1:0] opnd_q;    // mul: multiplicand, div: divisor magnitude
    logic             is_div_q;
    logic             is_rem_q;
    logic             hi_sel_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             b_zero_q;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Operand magnitudes for signed division; unsigned ops pass straight through.
    always_comb begin
        op_signed = (op == OP_DIV) || (op == OP_REM);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? ({WIDTH{1'b0}} - a) : a;
        b_mag     = b_neg ? ({WIDTH{1'b0}} - b) : b;
    end

    // One iteration step: shift-add for mul, restoring subtract for div.
    // The low WIDTH bits of the subtraction are exact whenever it is kept.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
        shifted = {acc_q, lo_q[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            if (shifted >= {1'b0, opnd_q}) begin
                acc_nx = diff;
                lo_nx  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = shifted[WIDTH-1:0];
                lo_nx  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Result selection with sign fixup; divide by zero forces an all-ones quotient.
    // The overflow case (most-negative / -1) falls out of the magnitude path.
    always_comb begin
        quo = b_zero_q ? {WIDTH{1'b1}} : (neg_q_q ? ({WIDTH{1'b0}} - lo_nx) : lo_nx);
        rem = neg_r_q ? ({WIDTH{1'b0}} - acc_nx) : acc_nx;
        if (is_div_q) begin
            result = is_rem_q ? rem : quo;
        end else begin
            result = hi_sel_q ? acc_nx : lo_nx;
        end
    end

    assign done = run && (cnt_q == {CW{1'b1}});

    // Load operands on start, then step once per run cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            hi_sel_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (start) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            is_div_q <= op[2];
            is_rem_q <= op[1];
            hi_sel_q <= op[0];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            b_zero_q <= (b == '0);
            if (op[2]) begin
                lo_q   <= a_mag;
                opnd_q <= b_mag;
            end else begin
                lo_q   <= b;
                opnd_q <= a;
            end
        end else if (run) begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= acc_nx;
            lo_q  <= lo_nx;
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered, handshaked EX-stage ALU: single-cycle ops plus an iterative
// mul/div path. The FSM state is fully visible on the ports: in_ready marks
// IDLE, busy marks BUSY, out_valid marks DONE.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid & in_ready; an output transfer happens on a rising edge where
// out_valid & out_ready. Only one op is in flight; out and out_valid hold
// steady until the output transfer.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             slt;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    // Single-cycle datapath; undefined codes produce zero.
    always_comb begin
        alu_res = '0;
        shamt   = inputB[SHW-1:0];
        slt     = $signed(inputA) < $signed(inputB);
        case (op)
            OP_ADD:  alu_res = inputA + inputB;
            OP_SUB:  alu_res = inputA - inputB;
            OP_SLL:  alu_res = inputA << shamt;
            OP_SRL:  alu_res = inputA >> shamt;
            OP_SRA:  alu_res = $signed(inputA) >>> shamt;
            OP_OR:   alu_res = inputA | inputB;
            OP_SLT:  alu_res = {{(WIDTH - 1){1'b0}}, slt};
            OP_ZERO: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .run    (busy),
        .op     (op),
        .a      (inputA),
        .b      (inputB),
        .done   (md_done),
        .result (md_result)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter_op(op)) begin
                        md_start = 1'b1;
                        state_d  = ST_BUSY;
                    end else begin
                        out_d   = alu_res;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    out_d   = md_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts any op in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv (WIDTH=32): vector table plus
// hand-written sequences for reset abort and output back-pressure.
module tb_alu_seq_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] inputA;
    logic [W-1:0] inputB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic [7:0]   lat;
    } vec_t;

    vec_t vecs[$];

    alu_seq_muldiv #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .inputA    (inputA),
        .inputB    (inputB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] e, input logic [7:0] l);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.b   = b;
        v.exp = e;
        v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Driver: waits for in_ready (bounded), presents one op for one cycle.
    task automatic drive_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", {31'b0, in_ready}, 1);
        op       = o;
        inputA   = a;
        inputB   = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issue one vector, measure latency, compare result, retire it.
    task automatic run_vec(input vec_t v, input string name);
        int lat;
        logic stall_ok;
        logic [W-1:0] req;
        exp_q.push_back(v.exp);
        drive_op(v.op, v.a, v.b);
        lat      = 1;
        stall_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, {24'b0, v.lat});
        if (v.lat > 8'd1) check({name, "_stall"}, {31'b0, stall_ok}, 1);
        req = exp_q.pop_front();
        check({name, "_out"}, out, req);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_retire"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic       saw_valid;
        logic       hold_ok;
        int         guard;
        logic [W-1:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        inputA    = '0;
        inputB    = '0;

        // Vector table: op, A, B, expected, latency
        vecs.push_back(mk(4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 8'd1));  // add wrap
        vecs.push_back(mk(4'b0011, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 8'd1));  // sub
        vecs.push_back(mk(4'b0001, 32'h00000001, 32'h00000021, 32'h00000002, 8'd1));  // sll masked
        vecs.push_back(mk(4'b0010, 32'h80000000, 32'h00000024, 32'hF8000000, 8'd1));  // sra
        vecs.push_back(mk(4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 8'd1));  // srl
        vecs.push_back(mk(4'b0110, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 8'd1));  // or
        vecs.push_back(mk(4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 8'd1));  // slt -1<1
        vecs.push_back(mk(4'b0100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 8'd1));  // slt 1<-1
        vecs.push_back(mk(4'b0111, 32'h12345678, 32'h00000001, 32'h00000000, 8'd1));  // 111 -> 0
        vecs.push_back(mk(4'b1010, 32'h12345678, 32'h00000003, 32'h00000000, 8'd1));  // undefined
        vecs.push_back(mk(4'b1011, 32'h12345678, 32'h00000003, 32'h00000000, 8'd1));  // undefined
        vecs.push_back(mk(4'b1000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 8'd33)); // mul
        vecs.push_back(mk(4'b1001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 8'd33)); // mulhu
        vecs.push_back(mk(4'b1000, 32'h12345678, 32'h00000010, 32'h23456780, 8'd33)); // mul
        vecs.push_back(mk(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd33)); // mulhu max
        vecs.push_back(mk(4'b1100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd33)); // div -7/2
        vecs.push_back(mk(4'b1110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd33)); // rem -7/2
        vecs.push_back(mk(4'b1100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 8'd33)); // div 7/-2
        vecs.push_back(mk(4'b1110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 8'd33)); // rem 7/-2
        vecs.push_back(mk(4'b1101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 8'd33)); // divu 7/0
        vecs.push_back(mk(4'b1110, 32'h00000005, 32'h00000000, 32'h00000005, 8'd33)); // rem 5/0
        vecs.push_back(mk(4'b1100, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFFF, 8'd33)); // div -8/0
        vecs.push_back(mk(4'b1110, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 8'd33)); // rem -8/0
        vecs.push_back(mk(4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd33)); // div ovf
        vecs.push_back(mk(4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd33)); // rem ovf
        vecs.push_back(mk(4'b1101, 32'h00000064, 32'h00000007, 32'h0000000E, 8'd33)); // divu 100/7
        vecs.push_back(mk(4'b1111, 32'h00000064, 32'h00000007, 32'h00000002, 8'd33)); // remu 100/7

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_out", out, 32'h0);
        check("reset_flags", {29'b0, out_valid, busy, in_ready}, 32'd1);

        // Reset in the middle of a multiply, then continue normally
        drive_op(4'b1000, 32'h00000003, 32'h00000005);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midstream_reset_flags", {29'b0, out_valid, busy, in_ready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: hold out_ready low 10 cycles with a competing in_valid
        drive_op(4'b1000, 32'hFFFFFFFF, 32'h00000002);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("hold_reached_done", {31'b0, out_valid}, 1);
        op       = 4'b0000;
        inputA   = 32'd3;
        inputB   = 32'd4;
        in_valid = 1'b1;
        hold_ok  = 1'b1;
        held     = 32'hFFFFFFFE;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || in_ready || busy || out !== held) hold_ok = 1'b0;
            @(negedge clk);
        end
        check("hold_stable", {31'b0, hold_ok}, 1);
        check("hold_out", out, 32'hFFFFFFFE);
        // Retire with in_valid still high: the new op waits for IDLE
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_to_idle", {29'b0, out_valid, busy, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("accept_after_retire_valid", {31'b0, out_valid}, 1);
        check("accept_after_retire_out", out, 32'd7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset on the 12th BUSY cycle of a divide
        drive_op(4'b1100, 32'h00000064, 32'h00000007);
        repeat (11) @(negedge clk);
        check("div_busy_12th", {31'b0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("div_abort_flags", {29'b0, out_valid, busy, in_ready}, 32'd1);
        check("div_abort_out", out, 32'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("div_abort_no_result", {31'b0, saw_valid}, 0);
        run_vec(mk(4'b0000, 32'd3, 32'd4, 32'd7, 8'd1), "post_abort_add");

        check("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
